handshake_rr_arbiter: RTL and testbench

- Shares one downstream ready/valid channel between NUM_REQ upstream ready/valid sources.
- Grants one source per packet (a packet ends on its `last` beat) using round-robin order.
- Drives the winning source's beats through a single registered output slice. The winner's index is reported alongside the data.
- Sits between several upstream producers and one downstream handshake consumer.

---
 rtl/handshake_rr_arbiter.sv | 165 ++++++++++++++++
 tb/tb_handshake_rr_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_rr_arbiter.sv
// Round-robin packet arbiter: NUM_REQ ready/valid sources share one registered ready/valid output.
// Define HANDSHAKE_ARB_BURST_LIMIT_EN to release the grant after MAX_BURST beats even without last.
module handshake_rr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        s_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] s_data_i,
  input  logic [NUM_REQ-1:0]        s_last_i,
  output logic [NUM_REQ-1:0]        s_ready_o,
  output logic                      m_valid_o,
  output logic [DATA_W-1:0]         m_data_o,
  output logic                      m_last_o,
  output logic [ID_W-1:0]           m_src_o,
  input  logic                      m_ready_i
);

  if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_BURST < 1) begin : g_param_check
    $error("handshake_rr_arbiter: illegal parameter value");
  end

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic                m_valid_q, m_valid_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic                m_last_q, m_last_d;
  logic [ID_W-1:0]     m_src_q, m_src_d;

  logic [ID_W-1:0]     pick_s;
  logic [ID_W:0]       sum_s;
  logic [ID_W-1:0]     grant_inc_s;
  logic [NUM_REQ-1:0]  s_ready_s;
  logic                slot_free_s;
  logic                accept_s;
  logic                burst_done_s;
  logic [DATA_W-1:0]   data_arr_s [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_data_split
    assign data_arr_s[k] = s_data_i[k*DATA_W +: DATA_W];
  end

  assign grant_inc_s = (grant_q == ID_W'(NUM_REQ - 1)) ? ID_W'(0) : grant_q + ID_W'(1);

  // Round-robin pick: scanning offsets downward leaves the nearest valid requester at or after rr_q.
  always_comb begin
    pick_s = rr_q;
    sum_s  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum_s  = {1'b0, rr_q} + (ID_W+1)'(i);
      sum_s  = (sum_s >= (ID_W+1)'(NUM_REQ)) ? sum_s - (ID_W+1)'(NUM_REQ) : sum_s;
      pick_s = s_valid_i[sum_s[ID_W-1:0]] ? sum_s[ID_W-1:0] : pick_s;
    end
  end

`ifdef HANDSHAKE_ARB_BURST_LIMIT_EN
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign burst_done_s = (cnt_q == CNT_W'(MAX_BURST - 1));

  // Beats accepted in the current grant; cleared whenever a new grant is issued.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = CNT_W'(0);
    end else if (accept_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= CNT_W'(0);
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign burst_done_s = 1'b0;
`endif

  // Arbitration FSM and output slice next-state.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    m_src_d     = m_src_q;
    s_ready_s   = '0;
    slot_free_s = !m_valid_q || m_ready_i;
    accept_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|s_valid_i) begin
          state_d = BUSY;
          grant_d = pick_s;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        s_ready_s[grant_q] = slot_free_s;
        accept_s           = slot_free_s && s_valid_i[grant_q];
        if (accept_s && (s_last_i[grant_q] || burst_done_s)) begin
          state_d = IDLE;
          rr_d    = grant_inc_s;
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept_s) begin
      m_valid_d = 1'b1;
      m_data_d  = data_arr_s[grant_q];
      m_last_d  = s_last_i[grant_q];
      m_src_d   = grant_q;
    end else if (m_ready_i) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= ID_W'(0);
      rr_q      <= ID_W'(0);
      m_valid_q <= 1'b0;
      m_data_q  <= DATA_W'(0);
      m_last_q  <= 1'b0;
      m_src_q   <= ID_W'(0);
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      m_src_q   <= m_src_d;
    end
  end

  assign s_ready_o = s_ready_s;
  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign m_last_o  = m_last_q;
  assign m_src_o   = m_src_q;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Bench for handshake_rr_arbiter: per-cycle transaction model plus literal beat-log expectations.
module tb_handshake_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 2;
`ifdef HANDSHAKE_ARB_BURST_LIMIT_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef bit [8:0] beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  s_valid_i = '0;
  logic [N*DW-1:0] s_data_i = '0;
  logic [N-1:0]  s_last_i = '0;
  logic [N-1:0]  s_ready_o;
  logic          m_valid_o;
  logic [DW-1:0] m_data_o;
  logic          m_last_o;
  logic [1:0]    m_src_o;
  logic          m_ready_i = 1'b1;

  handshake_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_last_i(s_last_i), .s_ready_o(s_ready_o),
    .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_last_o(m_last_o), .m_src_o(m_src_o),
    .m_ready_i(m_ready_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  beat_t srcq [N][$];
  logic [N-1:0] hold_r = '0;
  int log_q[$];

  // model state: owner -1 means no grant
  int own, ptr, beats, md, ms, exp_rdy;
  bit mv, ml, acc, found;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int enc(input int s, input int l, input int d);
    return s * 512 + l * 256 + d;
  endfunction

  // Compare DUT against the model, then advance the model with the inputs of the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      own = -1; ptr = 0; beats = 0; mv = 0; md = 0; ml = 0; ms = 0;
    end else begin
      exp_rdy = (own >= 0 && (!mv || m_ready_i)) ? (1 << own) : 0;
      check("s_ready", int'(s_ready_o), exp_rdy);
      check("m_valid", int'(m_valid_o), int'(mv));
      if (mv) begin
        check("m_data", int'(m_data_o), md);
        check("m_last", int'(m_last_o), int'(ml));
        check("m_src", int'(m_src_o), ms);
      end
      if (m_valid_o && m_ready_i)
        log_q.push_back(enc(int'(m_src_o), int'(m_last_o), int'(m_data_o)));
      acc = (exp_rdy != 0) && (((s_valid_i >> own) & 4'b1) != 4'b0);
      if (acc) begin
        mv = 1; ms = own;
        md = int'((s_data_i >> (own * DW)) & 32'hFF);
        ml = ((s_last_i >> own) & 4'b1) != 4'b0;
      end else if (m_ready_i) begin
        mv = 0;
      end
      if (own < 0) begin
        found = 0;
        for (int j = 0; j < N; j++) begin
          if (!found && (((s_valid_i >> ((ptr + j) % N)) & 4'b1) != 4'b0)) begin
            own = (ptr + j) % N; found = 1; beats = 0;
          end
        end
      end else if (acc) begin
        beats++;
        if (ml || (BURST && beats == MB)) begin
          ptr = (own + 1) % N; own = -1;
        end
      end
    end
  end

  // Source drivers: pop a beat after each handshake, present the queue head unless held.
  logic [N-1:0] take;
  logic [N-1:0] nv, nl;
  logic [N*DW-1:0] nd;
  always begin
    @(negedge clk);
    take = s_valid_i & s_ready_o;
    @(posedge clk);
    #1;
    nv = '0; nl = '0; nd = '0;
    for (int k = 0; k < N; k++) begin
      if (((take >> k) & 4'b1) != 4'b0 && srcq[k].size() > 0) void'(srcq[k].pop_front());
      if (srcq[k].size() > 0 && ((hold_r >> k) & 4'b1) == 4'b0) begin
        nv = nv | (4'b1 << k);
        nl = nl | (N'(srcq[k][0][8]) << k);
        nd = nd | ((N*DW)'(srcq[k][0][7:0]) << (k * DW));
      end
    end
    s_valid_i = nv; s_last_i = nl; s_data_i = nd;
  end

  task automatic push_pkt(input int k, input int base, input int n);
    for (int i = 0; i < n; i++) srcq[k].push_back({(i == n - 1), 8'(base + i)});
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < N; k++) if (srcq[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(all_empty() && s_valid_i == '0 && !m_valid_o) && n < 300);
    check({name, "_drain"}, int'(all_empty() && !m_valid_o), 1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!m_valid_o && n < 50);
    check({name, "_wait_valid"}, int'(m_valid_o), 1);
  endtask

  task automatic expect_log(input string name, input int exp[$]);
    check({name, "_count"}, log_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log_q.size(); i++) check(name, log_q[i], exp[i]);
    log_q.delete();
  endtask

  // Asynchronous reset pulse away from the clock edge; outputs must drop at once.
  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("rst_async_m_valid", int'(m_valid_o), 0);
    check("rst_async_s_ready", int'(s_ready_o), 0);
    for (int k = 0; k < N; k++) srcq[k].delete();
    log_q.delete();
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  int e[$];
  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_m_valid", int'(m_valid_o), 0);
    check("reset_m_data", int'(m_data_o), 0);
    check("reset_m_last", int'(m_last_o), 0);
    check("reset_m_src", int'(m_src_o), 0);
    check("reset_s_ready", int'(s_ready_o), 0);

    // single source, 3-beat packet
    push_pkt(0, 8'hA0, 3);
    drain("t1");
    e = '{enc(0, 0, 8'hA0), enc(0, 0, 8'hA1), enc(0, 1, 8'hA2)};
    expect_log("t1_log", e);

    // all requesters, single-beat packets, fair rotation from pointer 0
    do_reset();
    for (int j = 0; j < 2; j++) for (int k = 0; k < N; k++) push_pkt(k, k * 16 + j, 1);
    drain("t2");
    e = '{enc(0, 1, 8'h00), enc(1, 1, 8'h10), enc(2, 1, 8'h20), enc(3, 1, 8'h30),
          enc(0, 1, 8'h01), enc(1, 1, 8'h11), enc(2, 1, 8'h21), enc(3, 1, 8'h31)};
    expect_log("t2_log", e);

    // downstream stall mid-packet from requester 2
    push_pkt(2, 8'hC0, 3);
    wait_valid("t3");
    @(posedge clk); #1 m_ready_i = 1'b0;
    @(negedge clk);
    check("t3_stall_data", int'(m_data_o), 8'hC1);
    check("t3_stall_src", int'(m_src_o), 2);
    check("t3_stall_ready", int'(s_ready_o), 0);
    repeat (3) @(posedge clk);
    #1 m_ready_i = 1'b1;
    drain("t3");
    e = '{enc(2, 0, 8'hC0), enc(2, 0, 8'hC1), enc(2, 1, 8'hC2)};
    expect_log("t3_log", e);

    // requester 1 pauses mid-packet while requester 3 waits
    push_pkt(1, 8'hB0, 4);
    wait_valid("t4");
    push_pkt(3, 8'hD0, 1);
    @(posedge clk); #1 hold_r = 4'b0010;
    @(negedge clk);
    check("t4_ready3", int'(s_ready_o[3]), 0);
    repeat (3) @(posedge clk);
    #1 hold_r = 4'b0000;
    drain("t4");
    e = '{enc(1, 0, 8'hB0), enc(1, 0, 8'hB1), enc(1, 0, 8'hB2), enc(1, 1, 8'hB3), enc(3, 1, 8'hD0)};
    expect_log("t4_log", e);

    // reset mid-packet with pointer at 1; arbitration must restart from requester 0
    do_reset();
    push_pkt(0, 8'hE0, 1);
    push_pkt(0, 8'hF0, 5);
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (log_q.size() < 2 && n < 50);
      check("t5_progress", int'(log_q.size() >= 2), 1);
    end
    do_reset();
    push_pkt(0, 8'h60, 1);
    push_pkt(1, 8'h70, 1);
    drain("t5");
    e = '{enc(0, 1, 8'h60), enc(1, 1, 8'h70)};
    expect_log("t5_log", e);

`ifdef HANDSHAKE_ARB_BURST_LIMIT_EN
    push_pkt(0, 8'h40, 4);
    push_pkt(1, 8'h50, 4);
    drain("t6");
    e = '{enc(0, 0, 8'h40), enc(0, 0, 8'h41), enc(1, 0, 8'h50), enc(1, 0, 8'h51),
          enc(0, 0, 8'h42), enc(0, 1, 8'h43), enc(1, 0, 8'h52), enc(1, 1, 8'h53)};
    expect_log("t6_log", e);
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
